mem_pipe: RTL and testbench
===========================

MEM_PIPE -- requirements
Module: mem_pipe

Interface
REQ-001 Param Words, 4096, number of DataWidth-bit storage words.
REQ-002 Param DataWidth, 32, word width in bits; SHALL be a multiple of 8.
REQ-003 Param AddrWidth, 24, request address width in bits.
REQ-004 Param ReadLatency, 2, cycles from read acceptance to response; legal range 1..4.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 DataIn  in  DataWidth  write data.
REQ-008 Address  in  AddrWidth  word address.
REQ-009 MemReq  in  1  request valid.
REQ-010 RdWrBar  in  1  1 = read, 0 = write.
REQ-011 ByteEn  in  DataWidth/8  per-byte write strobe, bit i covers DataIn[8i+7:8i].
REQ-012 MemReady  out  1  request accepted when MemReq && MemReady.
REQ-013 DataOut  out  DataWidth  read response data.
REQ-014 DataValid  out  1  response valid.
REQ-015 DataReady  in  1  consumer accepts response when DataValid && DataReady.
REQ-016 AddrErr  out  1  qualifies the current response: read address >= Words.
REQ-017 WrErr  out  1  one-cycle pulse: dropped out-of-range write.

Function
REQ-018 Accepted write SHALL update storage at the accepting edge; out-of-range write SHALL leave storage unchanged and pulse WrErr in the following cycle.
REQ-019 Accepted read in cycle N SHALL enter the response path at N+ReadLatency; DataValid SHALL assert in that cycle if no older responses are pending.
REQ-020 Responses SHALL be returned strictly in request order.
REQ-021 Out-of-range read SHALL return DataOut = 0 with AddrErr = 1; in-range reads return AddrErr = 0.
REQ-022 Read accepted the cycle after a write to the same address SHALL return the new data.
REQ-023 Response buffer depth SHALL be ReadLatency+1; Outstanding = reads in pipeline + buffered responses.
REQ-024 MemReady SHALL equal !rst && (Outstanding < ReadLatency+1); applies to reads and writes alike.
REQ-025 Outstanding SHALL increment on read acceptance, decrement on response handshake, remain unchanged when both occur in the same cycle.
REQ-026 DataOut/AddrErr SHALL be held stable while DataValid && !DataReady.
REQ-027 Buffer push and pop in the same cycle SHALL be legal when full or empty (empty: bypass not required, data appears next cycle at the earliest per REQ-019).
REQ-028 Buffer pointers SHALL wrap modulo ReadLatency+1.

Reset
REQ-029 While rst = 1: MemReady = 0, DataValid = 0, AddrErr = 0, WrErr = 0, DataOut = 0, Outstanding = 0, pointers = 0.
REQ-030 Reset mid-operation SHALL discard all in-flight reads; no DataValid for them after reset releases.
REQ-031 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-032 Macro MEM_PIPE_BYTE_EN_EN defined: writes honour ByteEn per byte; ByteEn = 0 write completes with no storage change.
REQ-033 Macro undefined: ByteEn port present but ignored; every write updates the full word.

Structure
REQ-034 Package mem_pipe_pkg SHALL hold parameter defaults, ReadLatency bounds and the ByteEn width function.
REQ-035 Response buffer SHALL be sub-module mem_resp_fifo (parametrised width DataWidth+1, depth ReadLatency+1).

Verification
REQ-036 Write 0xDEADBEEF to 0x10, read 0x10 next cycle, DataReady=1 -> DataValid at read+2, DataOut=0xDEADBEEF, AddrErr=0.
REQ-037 ByteEn=4'b0010, DataIn=0x0000AB00 over 0x11223344 (macro on) -> read 0x1122AB44; macro off -> 0x0000AB00.
REQ-038 DataReady=0, issue reads back-to-back -> MemReady drops after 3 accepted reads; release DataReady -> 3 responses in order, MemReady reasserts.
REQ-039 Read Address=4096 -> DataOut=0, AddrErr=1; write Address=5000 -> WrErr pulse, storage unchanged.
REQ-040 Two reads in flight, assert rst one cycle -> no DataValid afterwards, MemReady=1 cycle after rst drops, prior storage readable.
REQ-041 ReadLatency=1 and 4 builds: single read -> DataValid exactly 1 and 4 cycles after acceptance.

Source files
------------

// File: rtl/mem_pipe_pkg.sv
// Shared defaults and helpers for the mem_pipe storage pipeline.
// Holds parameter defaults, the legal ReadLatency range and the byte-enable width helper.
package mem_pipe_pkg;

   localparam int MP_WORDS            = 4096;
   localparam int MP_DATA_WIDTH       = 32;
   localparam int MP_ADDR_WIDTH       = 24;
   localparam int MP_READ_LATENCY     = 2;
   localparam int MP_READ_LATENCY_MIN = 1;
   localparam int MP_READ_LATENCY_MAX = 4;

   function automatic int be_width(input int data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/mem_resp_fifo.sv
// Small circular response buffer for mem_pipe; pointers wrap modulo Depth.
// Push and pop may happen in the same cycle, including when full.
module mem_resp_fifo
   import mem_pipe_pkg::*;
#(
   parameter int Width = MP_DATA_WIDTH + 1,
   parameter int Depth = MP_READ_LATENCY + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [Width-1:0] i_push_data,
   input  logic             i_pop,
   output logic             o_vld,
   output logic [Width-1:0] o_data
);

   localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int CntW = $clog2(Depth + 1);

   logic [Width-1:0] r_buf [Depth];
   logic [PtrW-1:0]  r_wr_ptr;
   logic [PtrW-1:0]  r_rd_ptr;
   logic [CntW-1:0]  r_count;
   logic             w_do_push;
   logic             w_do_pop;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   assign w_do_pop  = i_pop && (r_count != '0);
   assign w_do_push = i_push && ((r_count != CntW'(Depth)) || w_do_pop);
   assign o_vld     = (r_count != '0);
   assign o_data    = r_buf[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
         else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
      end
   end

   // When full, the slot being overwritten is the one popped this cycle.
   always_ff @(posedge clk) begin
      if (!rst && w_do_push) r_buf[r_wr_ptr] <= i_push_data;
   end

endmodule

// File: rtl/mem_pipe.sv
// Single-port word storage with a fixed-latency, in-order, back-pressured read path.
// Define MEM_PIPE_BYTE_EN_EN to make writes honour ByteEn; otherwise writes replace the full word.
module mem_pipe
   import mem_pipe_pkg::*;
#(
   parameter int Words       = MP_WORDS,
   parameter int DataWidth   = MP_DATA_WIDTH,
   parameter int AddrWidth   = MP_ADDR_WIDTH,
   parameter int ReadLatency = MP_READ_LATENCY
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [DataWidth-1:0]             DataIn,
   input  logic [AddrWidth-1:0]             Address,
   input  logic                             MemReq,
   input  logic                             RdWrBar,
   input  logic [be_width(DataWidth)-1:0]   ByteEn,
   output logic                             MemReady,
   output logic [DataWidth-1:0]             DataOut,
   output logic                             DataValid,
   input  logic                             DataReady,
   output logic                             AddrErr,
   output logic                             WrErr
);

   localparam int IdxW  = $clog2(Words);
   localparam int RespW = DataWidth + 1;
   localparam int Depth = ReadLatency + 1;
   localparam int CntW  = $clog2(Depth + 1);

   logic [DataWidth-1:0] r_mem [Words];
   logic [CntW-1:0]      r_outstanding;
   logic                 r_wr_err;
   logic                 w_ready;
   logic                 w_accept;
   logic                 w_rd_acc;
   logic                 w_wr_acc;
   logic                 w_in_range;
   logic                 w_pop;
   logic                 w_push;
   logic                 w_fifo_vld;
   logic [IdxW-1:0]      w_idx;
   logic [RespW-1:0]     w_rd_resp;
   logic [RespW-1:0]     w_push_resp;
   logic [RespW-1:0]     w_fifo_data;

   assign w_ready    = !rst && (r_outstanding < CntW'(Depth));
   assign w_accept   = MemReq && w_ready;
   assign w_rd_acc   = w_accept && RdWrBar;
   assign w_wr_acc   = w_accept && !RdWrBar;
   assign w_in_range = Address < AddrWidth'(Words);
   assign w_idx      = Address[IdxW-1:0];
   // Response word is {addr_err, data}; out-of-range reads carry zero data.
   assign w_rd_resp  = w_in_range ? {1'b0, r_mem[w_idx]} : {1'b1, {DataWidth{1'b0}}};

`ifdef MEM_PIPE_BYTE_EN_EN
   always_ff @(posedge clk) begin
      if (w_wr_acc && w_in_range) begin
         for (int b = 0; b < be_width(DataWidth); b++) begin
            if (ByteEn[b]) r_mem[w_idx][8*b +: 8] <= DataIn[8*b +: 8];
         end
      end
   end
`else
   logic w_unused_byte_en;
   assign w_unused_byte_en = ^ByteEn;

   always_ff @(posedge clk) begin
      if (w_wr_acc && w_in_range) r_mem[w_idx] <= DataIn;
   end
`endif

   // The FIFO register supplies the last latency cycle, so only ReadLatency-1 stages live here.
   generate
      if (ReadLatency == 1) begin : g_no_pipe
         assign w_push      = w_rd_acc;
         assign w_push_resp = w_rd_resp;
      end else begin : g_pipe
         logic [ReadLatency-2:0] r_vld;
         logic [RespW-1:0]       r_resp [ReadLatency-1];

         always_ff @(posedge clk) begin
            if (rst) begin
               r_vld <= '0;
            end else begin
               r_vld[0] <= w_rd_acc;
               for (int k = 1; k < ReadLatency - 1; k++) r_vld[k] <= r_vld[k-1];
            end
         end

         always_ff @(posedge clk) begin
            r_resp[0] <= w_rd_resp;
            for (int k = 1; k < ReadLatency - 1; k++) r_resp[k] <= r_resp[k-1];
         end

         assign w_push      = r_vld[ReadLatency-2];
         assign w_push_resp = r_resp[ReadLatency-2];
      end
   endgenerate

   mem_resp_fifo #(
      .Width (RespW),
      .Depth (Depth)
   ) u_resp_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_push),
      .i_push_data (w_push_resp),
      .i_pop       (w_pop),
      .o_vld       (w_fifo_vld),
      .o_data      (w_fifo_data)
   );

   assign w_pop = DataValid && DataReady;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_outstanding <= '0;
         r_wr_err      <= 1'b0;
      end else begin
         if (w_rd_acc && !w_pop)      r_outstanding <= r_outstanding + 1'b1;
         else if (!w_rd_acc && w_pop) r_outstanding <= r_outstanding - 1'b1;
         r_wr_err <= w_wr_acc && !w_in_range;
      end
   end

   assign MemReady  = w_ready;
   assign DataValid = !rst && w_fifo_vld;
   assign DataOut   = rst ? '0 : w_fifo_data[DataWidth-1:0];
   assign AddrErr   = DataValid && w_fifo_data[DataWidth];
   assign WrErr     = !rst && r_wr_err;

endmodule

// File: tb/tb_mem_pipe.sv
// Self-checking bench for mem_pipe: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations and ReadLatency=1/4 instances.
module tb_mem_pipe;

   localparam int TB_RL = 2;
   localparam int WORDS = 4096;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] DataIn = '0;
   logic [23:0] Address = '0;
   logic        MemReq = 1'b0;
   logic        RdWrBar = 1'b0;
   logic [3:0]  ByteEn = 4'hF;
   logic        DataReady = 1'b1;
   logic        MemReady, DataValid, AddrErr, WrErr;
   logic [31:0] DataOut;

   logic        x_rst = 1'b1;
   logic        x_req = 1'b0;
   logic        x_rdwr = 1'b0;
   logic [23:0] x_addr = '0;
   logic [31:0] x_din = '0;
   logic [31:0] x_do1, x_do4;
   logic        x_mr1, x_mr4, x_dv1, x_dv4, x_ae1, x_ae4, x_we1, x_we4;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   mem_pipe #(.ReadLatency(TB_RL)) u_dut (
      .clk(clk), .rst(rst), .DataIn(DataIn), .Address(Address), .MemReq(MemReq),
      .RdWrBar(RdWrBar), .ByteEn(ByteEn), .MemReady(MemReady), .DataOut(DataOut),
      .DataValid(DataValid), .DataReady(DataReady), .AddrErr(AddrErr), .WrErr(WrErr));

   mem_pipe #(.ReadLatency(1)) u_dut_l1 (
      .clk(clk), .rst(x_rst), .DataIn(x_din), .Address(x_addr), .MemReq(x_req),
      .RdWrBar(x_rdwr), .ByteEn(4'hF), .MemReady(x_mr1), .DataOut(x_do1),
      .DataValid(x_dv1), .DataReady(1'b1), .AddrErr(x_ae1), .WrErr(x_we1));

   mem_pipe #(.ReadLatency(4)) u_dut_l4 (
      .clk(clk), .rst(x_rst), .DataIn(x_din), .Address(x_addr), .MemReq(x_req),
      .RdWrBar(x_rdwr), .ByteEn(4'hF), .MemReady(x_mr4), .DataOut(x_do4),
      .DataValid(x_dv4), .DataReady(1'b1), .AddrErr(x_ae4), .WrErr(x_we4));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: pending responses with the cycle each becomes visible.
   typedef struct {
      logic [31:0] data;
      logic        err;
      int          due;
   } resp_t;

   resp_t       q[$];
   logic [31:0] ref_mem [WORDS];
   int          wr_err_cyc = -1;

   always @(posedge clk) begin
      bit    pop;
      bit    acc;
      resp_t r;
      if (rst) begin
         q.delete();
      end else begin
         pop = (q.size() > 0) && (q[0].due <= cyc) && DataReady;
         acc = MemReq && (q.size() < TB_RL + 1);
         if (pop) void'(q.pop_front());
         if (acc && RdWrBar) begin
            r.err  = (Address >= WORDS);
            r.data = r.err ? 32'h0 : ref_mem[Address[11:0]];
            r.due  = cyc + TB_RL;
            q.push_back(r);
         end else if (acc) begin
            if (Address >= WORDS) begin
               wr_err_cyc = cyc + 1;
            end else begin
`ifdef MEM_PIPE_BYTE_EN_EN
               for (int b = 0; b < 4; b++)
                  if (ByteEn[b]) ref_mem[Address[11:0]][8*b +: 8] = DataIn[8*b +: 8];
`else
               ref_mem[Address[11:0]] = DataIn;
`endif
            end
         end
      end
      cyc++;
   end

   always @(negedge clk) begin
      bit ev;
      ev = !rst && (q.size() > 0) && (q[0].due <= cyc);
      chk("MemReady", MemReady, !rst && (q.size() < TB_RL + 1));
      chk("DataValid", DataValid, ev);
      chk("WrErr", WrErr, !rst && (cyc == wr_err_cyc));
      if (ev) begin
         chk("DataOut", DataOut, q[0].data);
         chk("AddrErr", AddrErr, q[0].err);
      end
      if (rst) chk("DataOut_rst", DataOut, 32'h0);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic rd, input logic [23:0] a, input logic [31:0] d,
                        input logic [3:0] be);
      MemReq = 1'b1; RdWrBar = rd; Address = a; DataIn = d; ByteEn = be;
      step();
      MemReq = 1'b0;
   endtask

   task automatic wait_valid(input int start, output int lat, output logic [31:0] d,
                             output logic e);
      lat = -1; d = 32'h0; e = 1'b0;
      for (int i = 0; i < 12; i++) begin
         #2;
         if (DataValid) begin
            lat = cyc - start; d = DataOut; e = AddrErr;
            break;
         end
         step();
      end
   endtask

   initial begin
      int          c, lat, acc_cnt, nval, lat1, lat4;
      logic [31:0] d, d1, d4, exp37, exp_be0;
      logic        e, e1, e4;
      logic [31:0] got[$];
      logic [23:0] blist [6];
      logic [23:0] ptbl [5];
      logic [31:0] bexp [3];

      blist = '{24'h010, 24'h388, 24'h040, 24'h020, 24'h010, 24'h388};
      bexp  = '{32'hDEADBEEF, 32'hA5A5A5A5, 32'h0BADF00D};
      ptbl  = '{24'h010, 24'h020, 24'h040, 24'h388, 24'd4103};

      repeat (3) step();
      rst = 1'b0;
      #2 chk("ready_after_reset", MemReady, 1);

      issue(1'b0, 24'h040, 32'h0BADF00D, 4'hF);
      issue(1'b0, 24'h388, 32'hA5A5A5A5, 4'hF);

      issue(1'b0, 24'h010, 32'hDEADBEEF, 4'hF);
      c = cyc; issue(1'b1, 24'h010, 32'h0, 4'hF);
      wait_valid(c, lat, d, e);
      chk("rd_latency", lat, 2);
      chk("rd_after_wr_data", d, 32'hDEADBEEF);
      chk("rd_after_wr_err", e, 0);

      issue(1'b0, 24'h020, 32'h11223344, 4'hF);
      issue(1'b0, 24'h020, 32'h0000AB00, 4'b0010);
      c = cyc; issue(1'b1, 24'h020, 32'h0, 4'hF);
      wait_valid(c, lat, d, e);
`ifdef MEM_PIPE_BYTE_EN_EN
      exp37 = 32'h1122AB44; exp_be0 = 32'h1122AB44;
`else
      exp37 = 32'h0000AB00; exp_be0 = 32'h55667788;
`endif
      chk("byte_en_merge", d, exp37);
      issue(1'b0, 24'h020, 32'h55667788, 4'h0);
      c = cyc; issue(1'b1, 24'h020, 32'h0, 4'hF);
      wait_valid(c, lat, d, e);
      chk("byte_en_zero", d, exp_be0);

      c = cyc; issue(1'b1, 24'd4096, 32'h0, 4'hF);
      wait_valid(c, lat, d, e);
      chk("oor_rd_data", d, 32'h0);
      chk("oor_rd_err", e, 1);
      issue(1'b0, 24'd5000, 32'hFFFFFFFF, 4'hF);
      #2 chk("wrerr_pulse", WrErr, 1);
      step();
      #2 chk("wrerr_clear", WrErr, 0);
      c = cyc; issue(1'b1, 24'h388, 32'h0, 4'hF);
      wait_valid(c, lat, d, e);
      chk("oor_wr_no_change", d, 32'hA5A5A5A5);
      step();

      DataReady = 1'b0; acc_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         MemReq = 1'b1; RdWrBar = 1'b1; Address = blist[i];
         #1;
         if (MemReady) acc_cnt++;
         step();
      end
      MemReq = 1'b0;
      chk("bp_accepted", acc_cnt, 3);
      #2 chk("bp_ready_low", MemReady, 0);
      DataReady = 1'b1; got.delete();
      for (int i = 0; i < 10; i++) begin
         #2;
         if (DataValid) got.push_back(DataOut);
         step();
      end
      chk("bp_count", got.size(), 3);
      while (got.size() < 3) got.push_back(32'h0);
      for (int i = 0; i < 3; i++) chk("bp_order", got[i], bexp[i]);
      #2 chk("bp_ready_back", MemReady, 1);

      step();
      issue(1'b1, 24'h010, 32'h0, 4'hF);
      issue(1'b1, 24'h040, 32'h0, 4'hF);
      rst = 1'b1;
      step();
      rst = 1'b0;
      #2 chk("rst_ready", MemReady, 1);
      nval = 0;
      for (int i = 0; i < 6; i++) begin
         if (DataValid) nval++;
         step();
      end
      chk("rst_discard", nval, 0);
      c = cyc; issue(1'b1, 24'h040, 32'h0, 4'hF);
      wait_valid(c, lat, d, e);
      chk("storage_kept", d, 32'h0BADF00D);
      step();

      for (int i = 0; i < 60; i++) begin
         MemReq    = (i % 3 != 2);
         RdWrBar   = (i % 4 != 0);
         Address   = ptbl[i % 5];
         DataIn    = 32'h10000000 + i * 32'h01010101;
         ByteEn    = 4'(i);
         DataReady = (i % 5 != 3);
         step();
      end
      MemReq = 1'b0; DataReady = 1'b1;
      repeat (10) step();

      x_rst = 1'b0;
      step();
      x_req = 1'b1; x_rdwr = 1'b0; x_addr = 24'h003; x_din = 32'h12345678;
      step();
      c = cyc; x_rdwr = 1'b1;
      step();
      x_req = 1'b0;
      lat1 = -1; lat4 = -1; d1 = 32'h0; d4 = 32'h0; e1 = 1'b1; e4 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #2;
         if (x_dv1 && lat1 < 0) begin lat1 = cyc - c; d1 = x_do1; e1 = x_ae1; end
         if (x_dv4 && lat4 < 0) begin lat4 = cyc - c; d4 = x_do4; e4 = x_ae4; end
         step();
      end
      chk("l1_latency", lat1, 1);
      chk("l4_latency", lat4, 4);
      chk("l1_data", d1, 32'h12345678);
      chk("l4_data", d4, 32'h12345678);
      chk("l1_l4_err", {e1, e4}, 0);
      chk("l1_l4_ready", {x_mr1, x_mr4}, 2'b11);
      chk("l1_l4_wrerr", {x_we1, x_we4}, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      fails++;
      $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog expired");
   end

endmodule
